simon_round_ctrl: RTL and testbench
===================================

SIMON_ROUND_CTRL -- requirements
Module: simon_round_ctrl

Interface
REQ-001 Parameters SHALL be: N, default 16, word width; M, default 4, key words; T, default 32, round count; Cb, default 5, round-counter width (T <= 2^Cb).
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 nR  input  1  asynchronous, active-low reset.
REQ-004 newKey  input  1  key words valid from input unpacker.
REQ-005 newData  input  1  plaintext block valid from input unpacker.
REQ-006 outAck  input  1  output packer has taken the result.
REQ-007 loadKey  output  1  key-accept handshake to unpacker.
REQ-008 loadData  output  1  data-accept handshake to unpacker.
REQ-009 keyLd  output  1  datapath captures master key.
REQ-010 dataLd  output  1  datapath captures block, reloads key schedule from master key.
REQ-011 roundEn  output  1  datapath executes one round and one key-schedule step.
REQ-012 round  output  Cb  current round index.
REQ-013 outValid  output  1  result held stable for the output packer.
REQ-014 keyValid  output  1  master key loaded.
REQ-015 doneData  output  1  one-cycle pulse per block completed.
REQ-016 busy  output  1  high in DLOAD, ROUND, OUT.

Function
REQ-017 All outputs SHALL be registered; FSM states IDLE, KLOAD, DLOAD, ROUND, OUT.
REQ-018 IDLE with newKey=1 and loadKey=0 SHALL go to KLOAD; keyLd=1 and loadKey set on that edge.
REQ-019 KLOAD SHALL last one cycle, then IDLE; keyLd cleared, keyValid set.
REQ-020 IDLE with newData=1, loadData=0, keyValid=1, and no accepted key request that cycle SHALL go to DLOAD; dataLd=1 and loadData set on that edge.
REQ-021 When newKey and newData are both eligible in IDLE, the key SHALL win; data is accepted on a later IDLE cycle under the new key.
REQ-022 newData with keyValid=0 SHALL NOT be accepted; loadData stays 0.
REQ-023 loadKey (loadData) SHALL clear on the first edge where newKey (newData) is sampled 0, in any state; no new accept while still high.
REQ-024 DLOAD SHALL last one cycle, then ROUND with round=0.
REQ-025 ROUND SHALL assert roundEn every cycle for exactly T cycles, round incrementing 0..T-1; after round=T-1 go to OUT, round returns to 0.
REQ-026 round SHALL be 0 outside ROUND; it never wraps inside ROUND.
REQ-027 OUT SHALL hold outValid=1 until outAck is sampled 1; on that edge outValid clears, doneData pulses one cycle, state returns to IDLE.
REQ-028 outAck outside OUT SHALL be ignored.
REQ-029 Latency: data-accept edge to outValid rising = T+1 cycles when outAck stalls zero.
REQ-030 newKey arriving while busy SHALL NOT be accepted until IDLE; the block in flight completes with the old key.
REQ-031 keyLd, dataLd, roundEn SHALL be mutually exclusive.

Reset
REQ-032 nR low SHALL immediately force IDLE, all outputs 0, round=0, keyValid=0, regardless of state.
REQ-033 After reset mid-ROUND, no outValid or doneData SHALL appear for the aborted block; a new key is required before data.

Verification
REQ-034 Reset release, newKey=1 -> keyLd one cycle, loadKey=1 until newKey drops, keyValid=1.
REQ-035 T=32, key loaded, newData=1, outAck tied 1 -> dataLd 1 cycle, roundEn 32 cycles with round 0..31, outValid 1 cycle, doneData pulse; no gaps.
REQ-036 newData with keyValid=0 for 50 cycles -> loadData stays 0; then newKey -> key loaded, data accepted next IDLE cycle.
REQ-037 newKey and newData same cycle in IDLE -> KLOAD first, then DLOAD; newKey during ROUND -> not accepted until after doneData.
REQ-038 outAck held 0 for 10 cycles in OUT -> outValid stays 1, state holds; outAck=1 -> doneData pulse, IDLE.
REQ-039 nR low at round=15 -> all outputs 0 asynchronously, keyValid=0, no outValid afterwards.

Source files
------------

// File: rtl/simon_round_ctrl_if.sv
// Handshake and control bundle between the SIMON round controller and its neighbours.
// Latency: none, wires only.
// Backpressure: the output packer stalls the controller by holding outAck low.
interface simon_round_ctrl_if #(
    parameter int Cb = 5
);
    logic          newKey;
    logic          newData;
    logic          outAck;
    logic          loadKey;
    logic          loadData;
    logic          keyLd;
    logic          dataLd;
    logic          roundEn;
    logic [Cb-1:0] round;
    logic          outValid;
    logic          keyValid;
    logic          doneData;
    logic          busy;

    // Unpacker/packer side: drives the requests and the acknowledge.
    modport master (
        output newKey, newData, outAck,
        input  loadKey, loadData, keyLd, dataLd, roundEn, round,
               outValid, keyValid, doneData, busy
    );

    // Controller side.
    modport slave (
        input  newKey, newData, outAck,
        output loadKey, loadData, keyLd, dataLd, roundEn, round,
               outValid, keyValid, doneData, busy
    );
endinterface

// File: rtl/simon_round_ctrl.sv
// SIMON round controller: key/data accept handshakes, T-round sequencing, result hold.
// Latency: data-accept edge to outValid rising is T+1 cycles; every output is a flop.
// Backpressure: OUT holds outValid until outAck is sampled high; no new request is accepted until IDLE.
module simon_round_ctrl #(
    parameter int N  = 16,
    parameter int M  = 4,
    parameter int T  = 32,
    parameter int Cb = 5
) (
    input  logic               clk,
    input  logic               nR,
    simon_round_ctrl_if.slave  io
);

    // Parameter sanity: the round counter must be able to hold T-1 without wrapping.
    if (N < 1 || M < 1 || T < 1 || T > (2 ** Cb)) begin : g_bad_param
        $error("simon_round_ctrl: illegal parameter set");
    end

    localparam logic [Cb-1:0] LAST_ROUND = Cb'(T - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_KLOAD = 3'd1,
        S_DLOAD = 3'd2,
        S_ROUND = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic          load_key_q, load_key_d;
    logic          load_data_q, load_data_d;
    logic          key_ld_q, key_ld_d;
    logic          data_ld_q, data_ld_d;
    logic          round_en_q, round_en_d;
    logic [Cb-1:0] round_q, round_d;
    logic          out_valid_q, out_valid_d;
    logic          key_valid_q, key_valid_d;
    logic          done_data_q, done_data_d;
    logic          busy_q, busy_d;
    logic          key_acc;
    logic          data_acc;

    // Next state and next registered outputs; strobes default low, handshakes decay when the request drops.
    always_comb begin
        state_d     = state_q;
        load_key_d  = load_key_q & io.newKey;
        load_data_d = load_data_q & io.newData;
        key_ld_d    = 1'b0;
        data_ld_d   = 1'b0;
        round_en_d  = 1'b0;
        round_d     = '0;
        out_valid_d = 1'b0;
        key_valid_d = key_valid_q;
        done_data_d = 1'b0;
        key_acc     = 1'b0;
        data_acc    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A fresh key always wins over a pending block so the block runs under the new key.
                key_acc  = io.newKey & ~load_key_q;
                data_acc = io.newData & ~load_data_q & key_valid_q & ~key_acc;
                if (key_acc) begin
                    state_d    = S_KLOAD;
                    key_ld_d   = 1'b1;
                    load_key_d = 1'b1;
                end else if (data_acc) begin
                    state_d     = S_DLOAD;
                    data_ld_d   = 1'b1;
                    load_data_d = 1'b1;
                end
            end
            S_KLOAD: begin
                state_d     = S_IDLE;
                key_valid_d = 1'b1;
            end
            S_DLOAD: begin
                state_d    = S_ROUND;
                round_en_d = 1'b1;
                round_d    = '0;
            end
            S_ROUND: begin
                if (round_q == LAST_ROUND) begin
                    state_d     = S_OUT;
                    out_valid_d = 1'b1;
                end else begin
                    round_en_d = 1'b1;
                    round_d    = round_q + Cb'(1);
                end
            end
            S_OUT: begin
                if (io.outAck) begin
                    state_d     = S_IDLE;
                    done_data_d = 1'b1;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_DLOAD) || (state_d == S_ROUND) || (state_d == S_OUT);
    end

    // State and output registers; reset aborts any block in flight and forgets the key.
    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            state_q     <= S_IDLE;
            load_key_q  <= 1'b0;
            load_data_q <= 1'b0;
            key_ld_q    <= 1'b0;
            data_ld_q   <= 1'b0;
            round_en_q  <= 1'b0;
            round_q     <= '0;
            out_valid_q <= 1'b0;
            key_valid_q <= 1'b0;
            done_data_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_key_q  <= load_key_d;
            load_data_q <= load_data_d;
            key_ld_q    <= key_ld_d;
            data_ld_q   <= data_ld_d;
            round_en_q  <= round_en_d;
            round_q     <= round_d;
            out_valid_q <= out_valid_d;
            key_valid_q <= key_valid_d;
            done_data_q <= done_data_d;
            busy_q      <= busy_d;
        end
    end

    assign io.loadKey  = load_key_q;
    assign io.loadData = load_data_q;
    assign io.keyLd    = key_ld_q;
    assign io.dataLd   = data_ld_q;
    assign io.roundEn  = round_en_q;
    assign io.round    = round_q;
    assign io.outValid = out_valid_q;
    assign io.keyValid = key_valid_q;
    assign io.doneData = done_data_q;
    assign io.busy     = busy_q;

endmodule

// File: tb/tb_simon_round_ctrl.sv
// Directed bench for simon_round_ctrl with T=32: key load, block runs, stalls, key/data priority, async reset.
// Latency: inputs change and outputs are sampled on the falling clock edge.
// Backpressure: outAck is driven per scenario to exercise the OUT hold.
module tb_simon_round_ctrl;

    localparam int T  = 32;
    localparam int CB = 5;

    logic clk;
    logic nR;
    int   total;
    int   bad;

    simon_round_ctrl_if #(.Cb(CB)) bus ();

    simon_round_ctrl #(.N(16), .M(4), .T(T), .Cb(CB)) dut (
        .clk (clk),
        .nR  (nR),
        .io  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Strobes to the datapath must never overlap.
    always @(negedge clk) begin
        if (nR)
            check("strobe_excl", 32'(bus.keyLd) + 32'(bus.dataLd) + 32'(bus.roundEn) <= 32'd1, 32'd1);
    end

    // Run one block from the DLOAD state through the rounds; leaves the bench sampling the first OUT cycle.
    task automatic run_rounds(input string tag);
        for (int i = 0; i < T; i++) begin
            step();
            check({tag, "_roundEn"}, 32'(bus.roundEn), 32'd1);
            check({tag, "_round"}, 32'(bus.round), 32'(i));
            check({tag, "_outValid_in_round"}, 32'(bus.outValid), 32'd0);
        end
        step();
        check({tag, "_outValid_rise"}, 32'(bus.outValid), 32'd1);
        check({tag, "_round_back0"}, 32'(bus.round), 32'd0);
        check({tag, "_roundEn_off"}, 32'(bus.roundEn), 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        bus.newKey  = 1'b0;
        bus.newData = 1'b0;
        bus.outAck  = 1'b0;
        nR = 1'b1;
        #1 nR = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_keyValid", 32'(bus.keyValid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_round", 32'(bus.round), 32'd0);
        check("rst_outValid", 32'(bus.outValid), 32'd0);
        nR = 1'b1;

        // Key load: one keyLd cycle, loadKey held while newKey stays up.
        bus.newKey = 1'b1;
        step();
        check("k_keyLd", 32'(bus.keyLd), 32'd1);
        check("k_loadKey", 32'(bus.loadKey), 32'd1);
        check("k_keyValid_early", 32'(bus.keyValid), 32'd0);
        step();
        check("k_keyLd_clr", 32'(bus.keyLd), 32'd0);
        check("k_keyValid", 32'(bus.keyValid), 32'd1);
        check("k_loadKey_hold", 32'(bus.loadKey), 32'd1);
        step();
        check("k_no_reaccept", 32'(bus.keyLd), 32'd0);
        bus.newKey = 1'b0;
        step();
        check("k_loadKey_clr", 32'(bus.loadKey), 32'd0);

        // Full block with outAck tied high.
        bus.outAck  = 1'b1;
        bus.newData = 1'b1;
        step();
        check("a_dataLd", 32'(bus.dataLd), 32'd1);
        check("a_loadData", 32'(bus.loadData), 32'd1);
        check("a_busy", 32'(bus.busy), 32'd1);
        bus.newData = 1'b0;
        run_rounds("a");
        check("a_loadData_clr", 32'(bus.loadData), 32'd0);
        step();
        check("a_outValid_fall", 32'(bus.outValid), 32'd0);
        check("a_doneData", 32'(bus.doneData), 32'd1);
        check("a_busy_clr", 32'(bus.busy), 32'd0);
        step();
        check("a_doneData_pulse", 32'(bus.doneData), 32'd0);

        // Output stall: outAck low for 10 cycles in OUT.
        bus.outAck  = 1'b0;
        bus.newData = 1'b1;
        step();
        check("s_dataLd", 32'(bus.dataLd), 32'd1);
        bus.newData = 1'b0;
        run_rounds("s");
        for (int i = 0; i < 10; i++) begin
            step();
            check("s_hold_outValid", 32'(bus.outValid), 32'd1);
            check("s_hold_done", 32'(bus.doneData), 32'd0);
            check("s_hold_busy", 32'(bus.busy), 32'd1);
        end
        bus.outAck = 1'b1;
        step();
        check("s_outValid_fall", 32'(bus.outValid), 32'd0);
        check("s_doneData", 32'(bus.doneData), 32'd1);
        check("s_busy_clr", 32'(bus.busy), 32'd0);

        // New key raised during ROUND waits until the block is done.
        bus.newData = 1'b1;
        step();
        check("b_dataLd", 32'(bus.dataLd), 32'd1);
        bus.newData = 1'b0;
        bus.newKey  = 1'b1;
        for (int i = 0; i < T; i++) begin
            step();
            check("b_keyLd_blocked", 32'(bus.keyLd), 32'd0);
            check("b_loadKey_blocked", 32'(bus.loadKey), 32'd0);
            check("b_round", 32'(bus.round), 32'(i));
        end
        step();
        check("b_outValid", 32'(bus.outValid), 32'd1);
        check("b_keyLd_in_out", 32'(bus.keyLd), 32'd0);
        step();
        check("b_doneData", 32'(bus.doneData), 32'd1);
        check("b_keyLd_at_done", 32'(bus.keyLd), 32'd0);
        step();
        check("b_keyLd_after", 32'(bus.keyLd), 32'd1);
        bus.newKey = 1'b0;
        step();
        check("b_keyValid", 32'(bus.keyValid), 32'd1);

        // Asynchronous reset at round 15.
        bus.newData = 1'b1;
        step();
        check("r_dataLd", 32'(bus.dataLd), 32'd1);
        bus.newData = 1'b0;
        for (int i = 0; i < 16; i++) step();
        check("r_round15", 32'(bus.round), 32'd15);
        #2 nR = 1'b0;
        #1;
        check("r_async_roundEn", 32'(bus.roundEn), 32'd0);
        check("r_async_round", 32'(bus.round), 32'd0);
        check("r_async_keyValid", 32'(bus.keyValid), 32'd0);
        check("r_async_busy", 32'(bus.busy), 32'd0);
        check("r_async_outValid", 32'(bus.outValid), 32'd0);
        @(negedge clk);
        nR = 1'b1;

        // Data without a key for 50 cycles is never taken; also no stale result appears.
        bus.newData = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            check("n_loadData", 32'(bus.loadData), 32'd0);
            check("n_outValid", 32'(bus.outValid), 32'd0);
            check("n_doneData", 32'(bus.doneData), 32'd0);
        end

        // Key and data together: key first, then data on the next IDLE cycle.
        bus.newKey = 1'b1;
        step();
        check("p_keyLd", 32'(bus.keyLd), 32'd1);
        check("p_dataLd_lost", 32'(bus.dataLd), 32'd0);
        bus.newKey = 1'b0;
        step();
        check("p_keyValid", 32'(bus.keyValid), 32'd1);
        check("p_dataLd_wait", 32'(bus.dataLd), 32'd0);
        step();
        check("p_dataLd", 32'(bus.dataLd), 32'd1);
        bus.newData = 1'b0;
        bus.outAck  = 1'b1;
        run_rounds("p");
        step();
        check("p_doneData", 32'(bus.doneData), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
